lfsr_multi: RTL and testbench

- Multi-channel, run-controlled successor to the single-channel XNOR LFSR pattern generator, used for systolic-array stimulus and BIST data.
- NUM_CH independent Fibonacci LFSRs share one runtime tap mask, one feedback mode and one stop code.
- A small FSM runs all channels for a bounded number of steps, or until every channel has hit the stop code, then pulses done.

---
 rtl/lfsr_multi.sv | 103 ++++++++++
 tb/tb_lfsr_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_multi.sv
// lfsr_multi: NUM_CH Fibonacci LFSRs sharing taps/mode/stop code, run-controlled by a small FSM.
// Optional lock-up detection and recovery (o_lockup) is built when LFSR_LOCKUP_DET_EN is defined.
module lfsr_multi #(
    parameter int NUM_BITS = 32,
    parameter int NUM_CH   = 4,
    parameter int XNOR_FB  = 1,
    parameter int CNT_W    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic [NUM_CH*NUM_BITS-1:0] i_seed,
    input  logic [NUM_BITS-1:0]        i_taps,
    input  logic [NUM_BITS-1:0]        i_stop_code,
    input  logic [CNT_W-1:0]           i_max_steps,
    input  logic                       i_start,
    input  logic                       i_stall,
    input  logic                       i_abort,
    output logic                       o_busy,
    output logic                       o_vld,
    output logic [NUM_CH*NUM_BITS-1:0] o_data,
    output logic [NUM_CH-1:0]          o_match,
    output logic [CNT_W-1:0]           o_step_cnt,
    output logic                       o_done
`ifdef LFSR_LOCKUP_DET_EN
    ,output logic [NUM_CH-1:0]         o_lockup
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    fsm_t fsm, fsm_nxt;
    logic [NUM_CH*NUM_BITS-1:0] adv_data;
    logic [NUM_CH-1:0] hit, match_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic adv, term;
`ifdef LFSR_LOCKUP_DET_EN
    localparam logic [NUM_BITS-1:0] LOCK  = (XNOR_FB != 0) ? '1 : '0;
    localparam logic [NUM_BITS-1:0] RECOV = (XNOR_FB != 0) ? {1'b0, {(NUM_BITS-1){1'b1}}} : {1'b1, {(NUM_BITS-1){1'b0}}};
    logic [NUM_CH-1:0] lock_hit;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_BITS-1:0] cur, nxt;
        assign cur = o_data[c*NUM_BITS +: NUM_BITS];
`ifdef LFSR_LOCKUP_DET_EN
        // A channel flagged as stuck is kicked out of the lock-up state instead of shifting
        assign nxt = (o_lockup[c] && cur == LOCK) ? RECOV : {cur[NUM_BITS-2:0], ^(cur & i_taps) ^ (XNOR_FB != 0)};
        assign lock_hit[c] = nxt == LOCK;
`else
        assign nxt = {cur[NUM_BITS-2:0], ^(cur & i_taps) ^ (XNOR_FB != 0)};
`endif
        assign adv_data[c*NUM_BITS +: NUM_BITS] = nxt;
        assign hit[c] = nxt == i_stop_code;
    end

    assign adv       = fsm == RUN && !i_stall && !i_abort;
    assign cnt_nxt   = o_step_cnt + CNT_W'(1);
    assign match_nxt = o_match | hit;
    assign term      = (cnt_nxt == i_max_steps && i_max_steps != '0) || &match_nxt;
    assign o_busy    = fsm == RUN;
    assign o_done    = fsm == DONE;

    always_comb begin
        fsm_nxt = IDLE;
        if (fsm == IDLE)
            fsm_nxt = i_start ? RUN : IDLE;
        else if (fsm == RUN)
            fsm_nxt = i_abort ? IDLE : (adv && term) ? DONE : RUN;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm        <= IDLE;
            o_data     <= '0;
            o_match    <= '0;
            o_step_cnt <= '0;
            o_vld      <= 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
            o_lockup   <= '0;
`endif
        end else begin
            fsm   <= fsm_nxt;
            o_vld <= adv;
            if (fsm == IDLE) begin
                if (i_load)
                    o_data <= i_seed;
                if (i_start) begin
                    o_match    <= '0;
                    o_step_cnt <= '0;
`ifdef LFSR_LOCKUP_DET_EN
                    o_lockup   <= '0;
`endif
                end
            end else if (adv) begin
                o_data     <= adv_data;
                o_match    <= match_nxt;
                o_step_cnt <= cnt_nxt;
`ifdef LFSR_LOCKUP_DET_EN
                o_lockup   <= o_lockup | lock_hit;
`endif
            end
        end
    end
endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi: scoreboard bench for lfsr_multi; an XOR 4-bit/2-channel instance and an XNOR 4-bit/1-channel instance.
module tb_lfsr_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic load0, start0, load1, start1, stall, abort;
    logic [7:0] seed0, max0, max1;
    logic [3:0] seed1, taps, stop0, stop1;
    logic vld0, busy0, done0, vld1, busy1, done1;
    logic [7:0] data0, cnt0, cnt1;
    logic [3:0] data1;
    logic [1:0] match0;
    logic [0:0] match1;
`ifdef LFSR_LOCKUP_DET_EN
    logic [1:0] lock0;
    logic [0:0] lock1;
`endif

    lfsr_multi #(.NUM_BITS(4), .NUM_CH(2), .XNOR_FB(0), .CNT_W(8)) u0 (
        .i_clk(clk), .i_rst(rst), .i_load(load0), .i_seed(seed0), .i_taps(taps),
        .i_stop_code(stop0), .i_max_steps(max0), .i_start(start0), .i_stall(stall),
        .i_abort(abort), .o_busy(busy0), .o_vld(vld0), .o_data(data0), .o_match(match0),
        .o_step_cnt(cnt0), .o_done(done0)
`ifdef LFSR_LOCKUP_DET_EN
        ,.o_lockup(lock0)
`endif
    );

    lfsr_multi #(.NUM_BITS(4), .NUM_CH(1), .XNOR_FB(1), .CNT_W(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_load(load1), .i_seed(seed1), .i_taps(taps),
        .i_stop_code(stop1), .i_max_steps(max1), .i_start(start1), .i_stall(stall),
        .i_abort(abort), .o_busy(busy1), .o_vld(vld1), .o_data(data1), .o_match(match1),
        .o_step_cnt(cnt1), .o_done(done1)
`ifdef LFSR_LOCKUP_DET_EN
        ,.o_lockup(lock1)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] q0 [$];
    logic [9:0] d0 [$];
    logic [3:0] q1 [$];
    logic [8:0] d1 [$];

    // Hand-computed steps for taps 1100, XOR, seeds ch0=0001 ch1=0110 (ch1 in upper nibble)
    logic [7:0] t1 [4] = '{8'b1101_0010, 8'b1010_0100, 8'b0101_1001, 8'b1011_0011};
    // Full period from 0001 with the same taps
    logic [3:0] s2 [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                            4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vld0) begin
                if (q0.size() == 0) chk("vld0_unexpected", vld0, 0);
                else chk("data0", data0, q0.pop_front());
            end
            if (done0) begin
                if (d0.size() == 0) chk("done0_unexpected", done0, 0);
                else chk("done0_cnt_match", {cnt0, match0}, d0.pop_front());
            end
            if (vld1) begin
                if (q1.size() == 0) chk("vld1_unexpected", vld1, 0);
                else chk("data1", data1, q1.pop_front());
            end
            if (done1) begin
                if (d1.size() == 0) chk("done1_unexpected", done1, 0);
                else chk("done1_cnt_match", {cnt1, match1}, d1.pop_front());
            end
        end
    end

    initial begin
        {load0, start0, load1, start1, stall, abort} = '0;
        seed0 = '0; seed1 = '0; max0 = '0; max1 = '0;
        stop0 = '0; stop1 = '0; taps = 4'b1100;
        cyc(2);
        chk("reset_state", {data0, match0, cnt0, vld0, busy0, done0}, 0);
        rst = 1'b0;
        cyc(1);

        // Test 1: bounded run of 4 steps
        seed0 = 8'h61; load0 = 1'b1; cyc(1); load0 = 1'b0;
        chk("load_data", data0, 8'h61);
        chk("load_no_vld", vld0, 0);
        foreach (t1[i]) q0.push_back(t1[i]);
        d0.push_back({8'd4, 2'b00});
        max0 = 8'd4; stop0 = 4'b1111;
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        chk("t1_busy", busy0, 1);
        cyc(8);
        chk("t1_idle", busy0, 0);
        chk("t1_cnt", cnt0, 8'd4);

        // Test 2: unlimited run ending when both channels return to 0001
        seed0 = 8'h11; load0 = 1'b1; cyc(1); load0 = 1'b0;
        foreach (s2[i]) q0.push_back({s2[i], s2[i]});
        d0.push_back({8'd15, 2'b11});
        max0 = 8'd0; stop0 = 4'b0001;
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(20);
        chk("t2_cnt", cnt0, 8'd15);
        chk("t2_match", match0, 2'b11);

        // Test 3: stall for 3 cycles after the first advance
        seed0 = 8'h61; load0 = 1'b1; cyc(1); load0 = 1'b0;
        foreach (t1[i]) q0.push_back(t1[i]);
        d0.push_back({8'd4, 2'b00});
        max0 = 8'd4; stop0 = 4'b1111;
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(1);
        stall = 1'b1; cyc(3);
        chk("stall_cnt", cnt0, 8'd1);
        chk("stall_data", data0, t1[0]);
        chk("stall_busy", busy0, 1);
        stall = 1'b0;
        cyc(8);

        // Test 4: abort after 2 steps, then restart from the held states
        seed0 = 8'h61; load0 = 1'b1; cyc(1); load0 = 1'b0;
        q0.push_back(t1[0]); q0.push_back(t1[1]);
        max0 = 8'd0; stop0 = 4'b1111;
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(2);
        abort = 1'b1; cyc(1); abort = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_cnt", cnt0, 8'd2);
        chk("abort_data", data0, t1[1]);
        cyc(2);
        q0.push_back(t1[2]); q0.push_back(t1[3]);
        d0.push_back({8'd2, 2'b00});
        max0 = 8'd2;
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(6);
        chk("restart_cnt", cnt0, 8'd2);

        // Test 5: reset mid-run, then simultaneous load and start
        seed0 = 8'h61; load0 = 1'b1; cyc(1); load0 = 1'b0;
        q0.push_back(t1[0]);
        max0 = 8'd0; stop0 = 4'b1111;
        start0 = 1'b1; cyc(1); start0 = 1'b0;
        cyc(2);
        rst = 1'b1; #1;
        chk("reset_midrun", {data0, match0, cnt0, vld0, busy0, done0}, 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        seed0 = 8'h16; max0 = 8'd2;
        q0.push_back(8'h2D); q0.push_back(8'h4A);
        d0.push_back({8'd2, 2'b00});
        load0 = 1'b1; start0 = 1'b1; cyc(1); load0 = 1'b0; start0 = 1'b0;
        chk("t5_busy", busy0, 1);
        chk("t5_seed", data0, 8'h16);
        cyc(6);

        // Test 6: XNOR lock-up seed
        seed1 = 4'hF; load1 = 1'b1; cyc(1); load1 = 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
        q1.push_back(4'b1111); q1.push_back(4'b0111); q1.push_back(4'b1110);
`else
        q1.push_back(4'b1111); q1.push_back(4'b1111); q1.push_back(4'b1111);
`endif
        d1.push_back({8'd3, 1'b0});
        max1 = 8'd3; stop1 = 4'b0000;
        start1 = 1'b1; cyc(1); start1 = 1'b0;
        cyc(1);
        chk("t6_step1", data1, 4'hF);
`ifdef LFSR_LOCKUP_DET_EN
        chk("t6_lockup", lock1, 1'b1);
`endif
        cyc(6);
        chk("t6_cnt", cnt1, 8'd3);

        chk("q0_drained", q0.size(), 0);
        chk("d0_drained", d0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("d1_drained", d1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
